wb_write_arbiter: RTL



---
 rtl/wb_write_arbiter_pkg.sv | 22 ++
 rtl/wb_pend_buf.sv | 89 ++++++++
 rtl/wb_write_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Bus typedefs describe the default 5-bit address / 32-bit data register file.
package wb_write_arbiter_pkg;

  localparam int RegNumLog2 = 5;

  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [31:0]           RegBus;

  localparam RegBus ZeroWord     = '0;
  localparam logic  WriteEnable  = 1'b1;
  localparam logic  WriteDisable = 1'b0;
  localparam logic  RstEnable    = 1'b0;

  // Source driving the write port on the next cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_POP  = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_pend_buf.sv
// Circular buffer of pending long-latency results with per-entry live bits,
// kill-by-address and an associative lookup for two decode read addresses.
module wb_pend_buf
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = RegNumLog2,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      push_live,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [ADDR_W-1:0]         kill_addr,
  input  logic [ADDR_W-1:0]         look_a,
  input  logic [ADDR_W-1:0]         look_b,
  output logic                      hit_a,
  output logic                      hit_b,
  output logic                      head_live,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  live_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  // Popped slots drop their live bit so only occupied entries can ever hit.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill && (addr_q[i] == kill_addr)) begin
          live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (push) begin
        live_q[tail_q] <= push_live;
        tail_q         <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == look_a)) hit_a = 1'b1;
      if (live_q[i] && (addr_q[i] == look_b)) hit_b = 1'b1;
    end
  end

  assign head_live = live_q[head_q];
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Owns the register-file write port: pipeline writeback has priority over
// buffered long-latency results; reports read-after-pending hazards to decode.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = RegNumLog2,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [ADDR_W-1:0]      pipe_addr,
  input  logic [DATA_W-1:0]      pipe_data,
  input  logic                   lu_valid,
  input  logic [ADDR_W-1:0]      lu_addr,
  input  logic [DATA_W-1:0]      lu_data,
  output logic                   lu_ready,
  input  logic [ADDR_W-1:0]      r_addr_a,
  input  logic                   re_a,
  input  logic [ADDR_W-1:0]      r_addr_b,
  input  logic                   re_b,
  output logic                   stall_req,
  output logic                   we,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [DATA_W-1:0]      w_data,
  output logic [$clog2(DEPTH):0] pend_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_win;
  logic              pop;
  logic              push;
  logic              push_live;
  logic              hit_a;
  logic              hit_b;
  logic              head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count;
  wb_sel_e           sel;

  assign lu_ready = (count < CNT_W'(DEPTH));

  // A result racing a pipeline write to the same register is older, so it
  // is enqueued already dead; results to r0 complete the handshake unqueued.
  always_comb begin
    pipe_win  = pipe_we && (pipe_addr != '0);
    pop       = 1'b0;
    sel       = SEL_IDLE;
    push      = lu_valid && lu_ready && (lu_addr != '0);
    push_live = !(pipe_win && (pipe_addr == lu_addr));
    if (pipe_win) begin
      sel = SEL_PIPE;
    end else if (count != '0) begin
      sel = SEL_POP;
      pop = 1'b1;
    end
  end

  wb_pend_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pend_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_live (push_live),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (pop),
    .kill      (pipe_win),
    .kill_addr (pipe_addr),
    .look_a    (r_addr_a),
    .look_b    (r_addr_b),
    .hit_a     (hit_a),
    .hit_b     (hit_b),
    .head_live (head_live),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      we     <= WriteDisable;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      case (sel)
        SEL_PIPE: begin
          we     <= WriteEnable;
          w_addr <= pipe_addr;
          w_data <= pipe_data;
        end
        SEL_POP: begin
          we     <= head_live;
          w_addr <= head_addr;
          w_data <= head_data;
        end
        default: we <= WriteDisable;
      endcase
    end
  end

  assign stall_req = (re_a && (r_addr_a != '0) && hit_a) ||
                     (re_b && (r_addr_b != '0) && hit_b);
  assign pend_cnt  = count;

endmodule
